// File: rtl/verb_mon_pkg.sv
// Shared types for the Verb event monitor: tone and topic codes, the event record
// and the observe FSM states.
package verb_mon_pkg;

   localparam int MON_DATA_WIDTH = 8;
   localparam int MON_TS_WIDTH   = 32;
   localparam int MON_CNT_WIDTH  = 16;

   typedef enum logic [2:0] {
      TRACE = 3'd0,
      DEBUG = 3'd1,
      INFO  = 3'd2,
      WARN  = 3'd3,
      ERROR = 3'd4,
      FATAL = 3'd5
   } tone_e;

   typedef enum logic [1:0] {
      TOPIC_NONE = 2'd0,
      STBL       = 2'd1,
      OBSERVE    = 2'd2
   } topic_e;

   typedef enum logic {
      OBS_IDLE = 1'b0,
      OBS_WAIT = 1'b1
   } obs_state_e;

   typedef struct packed {
      tone_e                      level;
      topic_e                     topic;
      logic [MON_TS_WIDTH-1:0]    ts;
      logic [MON_DATA_WIDTH-1:0]  data;
      logic [MON_CNT_WIDTH-1:0]   count;
   } event_t;

endpackage

// File: rtl/verb_mon_fifo.sv
// Event FIFO: DEPTH storage entries behind a registered head, so a record written
// into empty storage appears at the head one cycle later.
module verb_mon_fifo
   import verb_mon_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  event_t din,
   input  logic   pop,
   output event_t head,
   output logic   full,
   output logic   empty
);

   localparam int           AW       = $clog2(DEPTH);
   localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

   event_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     cnt;
   logic            head_v;
   logic            load;
   logic            wr;

   // A pop that refills the head frees a storage slot, so push-while-full still lands.
   assign load  = (cnt != '0) && (!head_v || pop);
   assign full  = (cnt == FULL_CNT) && !load;
   assign wr    = push && !full;
   assign empty = !head_v;

   // NOTE: storage has no reset; nothing reads an entry before it is written.
   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= din;
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         head_v <= 1'b0;
         head   <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (load) begin
            rd_ptr <= rd_ptr + 1'b1;
            head   <= mem[rd_ptr];
            head_v <= 1'b1;
         end else if (pop) begin
            head_v <= 1'b0;
         end
         cnt <= cnt + {{AW{1'b0}}, wr} - {{AW{1'b0}}, load};
      end
   end

endmodule

// File: rtl/verb_event_monitor.sv
// In-fabric stability and bounded-observe checker; each outcome becomes a
// timestamped record drained over valid/ready. Record field widths come from verb_mon_pkg.
module verb_event_monitor
   import verb_mon_pkg::*;
#(
   parameter int DATA_WIDTH = MON_DATA_WIDTH,
   parameter int TS_WIDTH   = MON_TS_WIDTH,
   parameter int CNT_WIDTH  = MON_CNT_WIDTH,
   parameter int DEPTH      = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stb_flag,
   input  logic [DATA_WIDTH-1:0]  stb_data,
   input  logic                   obs_start,
   input  logic [CNT_WIDTH-1:0]   obs_limit,
   input  logic                   obs_active,
   input  logic                   obs_flag,
   output logic                   ev_valid,
   input  logic                   ev_ready,
   output logic [2:0]             ev_level,
   output logic [1:0]             ev_topic,
   output logic [TS_WIDTH-1:0]    ev_time,
   output logic [DATA_WIDTH-1:0]  ev_data,
   output logic [CNT_WIDTH-1:0]   ev_count,
   output logic                   overflow,
   output logic                   obs_busy
);

   logic [TS_WIDTH-1:0]    ts_q;

   logic                   last_flag;
   logic [DATA_WIDTH-1:0]  last_data;
   logic [CNT_WIDTH-1:0]   stb_cycles;
   logic                   stb_stable;
   logic                   stb_ev;
   event_t                 stb_rec;

   obs_state_e             obs_state, obs_state_nx;
   logic [CNT_WIDTH-1:0]   obs_cnt, obs_cnt_nx;
   logic [CNT_WIDTH-1:0]   obs_lim, obs_lim_nx;
   logic [CNT_WIDTH-1:0]   obs_cnt_inc;
   logic                   obs_ev;
   event_t                 obs_rec;

   event_t                 stb_pend, obs_pend;
   logic                   stb_pend_v, obs_pend_v;
   logic                   stb_push, obs_push;
   logic                   fifo_full, fifo_empty;
   event_t                 fifo_din, fifo_head;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      stb_ev        = 1'b0;
      stb_rec       = '0;
      stb_rec.topic = STBL;
      stb_rec.ts    = ts_q;
      if (last_flag && stb_flag && stb_stable && (stb_data != last_data)) begin
         stb_ev        = 1'b1;
         stb_rec.level = ERROR;
         stb_rec.data  = stb_data;
         stb_rec.count = stb_cycles;
      end else if (last_flag && !stb_flag && stb_stable) begin
         stb_ev        = 1'b1;
         stb_rec.level = INFO;
         stb_rec.data  = last_data;
         stb_rec.count = stb_cycles;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_q       <= '0;
         last_flag  <= 1'b0;
         last_data  <= '0;
         stb_cycles <= '0;
         stb_stable <= 1'b0;
      end else begin
         ts_q      <= ts_q + 1'b1;
         last_flag <= stb_flag;
         last_data <= stb_data;
         if (stb_flag && !last_flag) begin
            stb_cycles <= CNT_WIDTH'(1);
            stb_stable <= 1'b1;
         end else if (stb_flag) begin
            if (stb_ev) stb_stable <= 1'b0;
            if (stb_cycles != '1) stb_cycles <= stb_cycles + 1'b1;
         end
      end
   end

   assign obs_cnt_inc = obs_cnt + 1'b1;

   always_comb begin
      obs_state_nx  = obs_state;
      obs_cnt_nx    = obs_cnt;
      obs_lim_nx    = obs_lim;
      obs_ev        = 1'b0;
      obs_rec       = '0;
      obs_rec.topic = OBSERVE;
      obs_rec.ts    = ts_q;
      case (obs_state)
         OBS_IDLE: begin
            if (obs_start) begin
               if (obs_limit == '0) begin
                  obs_ev        = 1'b1;
                  obs_rec.level = ERROR;
               end else begin
                  obs_lim_nx   = obs_limit;
                  obs_cnt_nx   = '0;
                  obs_state_nx = OBS_WAIT;
               end
            end
         end
         OBS_WAIT: begin
            if (obs_flag == obs_active) begin
               obs_ev        = 1'b1;
               obs_rec.level = INFO;
               obs_rec.count = obs_cnt;
               obs_state_nx  = OBS_IDLE;
            end else if (obs_cnt_inc == obs_lim) begin
               obs_ev        = 1'b1;
               obs_rec.level = ERROR;
               obs_rec.count = obs_lim;
               obs_state_nx  = OBS_IDLE;
            end else begin
               obs_cnt_nx = obs_cnt_inc;
            end
         end
         default: obs_state_nx = OBS_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         obs_state <= OBS_IDLE;
         obs_cnt   <= '0;
         obs_lim   <= '0;
      end else begin
         obs_state <= obs_state_nx;
         obs_cnt   <= obs_cnt_nx;
         obs_lim   <= obs_lim_nx;
      end
   end

   assign obs_busy = (obs_state == OBS_WAIT);

   // Stability wins the single FIFO write slot; observe waits a cycle.
   assign stb_push = stb_pend_v && !fifo_full;
   assign obs_push = obs_pend_v && !fifo_full && !stb_pend_v;
   assign fifo_din = stb_pend_v ? stb_pend : obs_pend;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stb_pend   <= '0;
         stb_pend_v <= 1'b0;
         obs_pend   <= '0;
         obs_pend_v <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (stb_ev) begin
            if (stb_pend_v && !stb_push) begin
               overflow <= 1'b1;
            end else begin
               stb_pend   <= stb_rec;
               stb_pend_v <= 1'b1;
            end
         end else if (stb_push) begin
            stb_pend_v <= 1'b0;
         end
         if (obs_ev) begin
            if (obs_pend_v && !obs_push) begin
               overflow <= 1'b1;
            end else begin
               obs_pend   <= obs_rec;
               obs_pend_v <= 1'b1;
            end
         end else if (obs_push) begin
            obs_pend_v <= 1'b0;
         end
      end
   end

   verb_mon_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (stb_push | obs_push),
      .din   (fifo_din),
      .pop   (ev_valid & ev_ready),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign ev_valid = !fifo_empty;
   assign ev_level = fifo_head.level;
   assign ev_topic = fifo_head.topic;
   assign ev_time  = fifo_head.ts;
   assign ev_data  = fifo_head.data;
   assign ev_count = fifo_head.count;

endmodule

// File: tb/tb_verb_event_monitor.sv
// Self-checking bench for verb_event_monitor: directed and randomized windows
// scored against a rule-level expectation of the record stream.
module tb_verb_event_monitor;

   localparam logic [2:0] L_INFO  = 3'd2;
   localparam logic [2:0] L_ERROR = 3'd4;
   localparam logic [1:0] T_STBL  = 2'd1;
   localparam logic [1:0] T_OBS   = 2'd2;

   typedef logic [60:0] rec_t;   // {level, topic, time, data, count}

   logic        clk = 1'b0;
   logic        rst;
   logic        stb_flag;
   logic [7:0]  stb_data;
   logic        obs_start;
   logic [15:0] obs_limit;
   logic        obs_active;
   logic        obs_flag;
   logic        ev_valid;
   logic        ev_ready;
   logic [2:0]  ev_level;
   logic [1:0]  ev_topic;
   logic [31:0] ev_time;
   logic [7:0]  ev_data;
   logic [15:0] ev_count;
   logic        overflow;
   logic        obs_busy;

   verb_event_monitor dut (
      .clk        (clk),
      .rst        (rst),
      .stb_flag   (stb_flag),
      .stb_data   (stb_data),
      .obs_start  (obs_start),
      .obs_limit  (obs_limit),
      .obs_active (obs_active),
      .obs_flag   (obs_flag),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_level   (ev_level),
      .ev_topic   (ev_topic),
      .ev_time    (ev_time),
      .ev_data    (ev_data),
      .ev_count   (ev_count),
      .overflow   (overflow),
      .obs_busy   (obs_busy)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          errors   = 0;
   int          edge_n   = 0;
   int          hold_bad = 0;
   rec_t        got[$];
   rec_t        exp_q[$];
   bit          held = 1'b0;
   rec_t        held_rec;
   rec_t        cur;
   logic [63:0] outs;
   logic [7:0]  dv [8];

   assign cur  = {ev_level, ev_topic, ev_time, ev_data, ev_count};
   assign outs = {ev_valid, ev_level, ev_topic, ev_time, ev_data, ev_count, overflow, obs_busy};

   // Collects popped records and flags any payload change while stalled.
   always @(negedge clk) begin
      if (rst) begin
         held = 1'b0;
      end else begin
         if (held && (!ev_valid || cur != held_rec)) hold_bad++;
         held     = ev_valid && !ev_ready;
         held_rec = cur;
         if (ev_valid && ev_ready) got.push_back(cur);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "timeout");
   end

   function automatic rec_t mk(input logic [2:0] lv, input logic [1:0] tp, input int ts,
                               input logic [7:0] d, input int cnt);
      return {lv, tp, 32'(ts), d, 16'(cnt)};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task tick();
      @(posedge clk);
      edge_n++;
      #1;
   endtask

   task automatic drain_and_compare(input string tag);
      stb_flag  = 1'b0;
      obs_start = 1'b0;
      ev_ready  = 1'b1;
      for (int w = 0; w < 40 && got.size() < exp_q.size(); w++) tick();
      repeat (4) tick();
      check({tag, " nrec"}, 64'(got.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check($sformatf("%s rec%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
   endtask

   // Expected records come straight from the window rules:
   // stability -> first change index or window length; observe -> miss count vs limit.
   task automatic run_round(input string tag, input bit stb_en, input int so, input int len,
                            input bit obs_en, input int os, input int lim, input bit act,
                            input int hit, input bit ign, input bit rdy_rand);
      int   base, endj, busy_n, i1, sts, ots;
      rec_t sr, orr;
      got.delete();
      exp_q.delete();
      base = edge_n;
      sts  = 0;
      ots  = 0;
      sr   = '0;
      orr  = '0;
      if (stb_en) begin
         i1 = 0;
         for (int i = 1; i < len; i++) if (i1 == 0 && dv[i] != dv[i-1]) i1 = i;
         if (i1 != 0) begin
            sts = base + so + i1;
            sr  = mk(L_ERROR, T_STBL, sts, dv[i1], i1);
         end else begin
            sts = base + so + len;
            sr  = mk(L_INFO, T_STBL, sts, dv[len-1], len);
         end
      end
      endj = 0;
      if (obs_en) begin
         if (lim == 0) begin
            ots = base + os;
            orr = mk(L_ERROR, T_OBS, ots, 8'h00, 0);
         end else if (hit < lim) begin
            endj = hit + 1;
            ots  = base + os + hit + 1;
            orr  = mk(L_INFO, T_OBS, ots, 8'h00, hit);
         end else begin
            endj = lim;
            ots  = base + os + lim;
            orr  = mk(L_ERROR, T_OBS, ots, 8'h00, lim);
         end
      end
      if (stb_en && obs_en && ots < sts) begin
         exp_q.push_back(orr);
         exp_q.push_back(sr);
      end else begin
         if (stb_en) exp_q.push_back(sr);
         if (obs_en) exp_q.push_back(orr);
      end

      busy_n = 0;
      for (int k = 0; k < 16; k++) begin
         stb_flag = stb_en && k >= so && k < so + len;
         if (stb_flag) stb_data = dv[k-so];
         else          stb_data = 8'($urandom);
         obs_start  = obs_en && (k == os || (ign && endj >= 1 && k == os + 1));
         obs_limit  = 16'(lim);
         obs_active = act;
         if (obs_en && k > os && k <= os + endj) obs_flag = (k - os == hit + 1) ? act : !act;
         else                                    obs_flag = 1'($urandom);
         ev_ready = rdy_rand ? 1'($urandom) : 1'b1;
         tick();
         busy_n += int'(obs_busy);
      end
      check({tag, " busy cycles"}, 64'(busy_n), 64'(endj));
      drain_and_compare(tag);
   endtask

   initial begin
      int   base, chg;
      logic [31:0] t_prev, t_cur;

      rst        = 1'b1;
      stb_flag   = 1'b0;
      stb_data   = '0;
      obs_start  = 1'b0;
      obs_limit  = '0;
      obs_active = 1'b0;
      obs_flag   = 1'b0;
      ev_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset outputs", outs, 64'd0);
      rst    = 1'b0;
      edge_n = 0;
      tick();
      check("idle after reset", outs, 64'd0);

      foreach (dv[i]) dv[i] = 8'hA5;
      run_round("stbl info", 1'b1, 0, 5, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);

      dv[0] = 8'h11; dv[1] = 8'h11; dv[2] = 8'h22; dv[3] = 8'h33;
      run_round("stbl error", 1'b1, 1, 4, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);

      run_round("obs info",  1'b0, 0, 1, 1'b1, 1, 4, 1'b1, 2, 1'b1, 1'b0);
      run_round("obs tmo",   1'b0, 0, 1, 1'b1, 0, 4, 1'b1, 9, 1'b0, 1'b0);
      run_round("obs lim0",  1'b0, 0, 1, 1'b1, 2, 0, 1'b0, 0, 1'b0, 1'b0);

      foreach (dv[i]) dv[i] = 8'h3C;
      run_round("same ts",   1'b1, 0, 3, 1'b1, 0, 5, 1'b0, 2, 1'b0, 1'b0);

      for (int r = 0; r < 40; r++) begin
         dv[0] = 8'($urandom);
         chg   = $urandom_range(1, 8);
         for (int i = 1; i < 8; i++) begin
            if (i < chg)       dv[i] = dv[0];
            else if (i == chg) dv[i] = dv[i-1] ^ 8'($urandom_range(1, 255));
            else               dv[i] = 8'($urandom);
         end
         run_round($sformatf("rand%0d", r), 1'($urandom), $urandom_range(0, 3),
                   $urandom_range(1, 6), 1'($urandom), $urandom_range(0, 4),
                   $urandom_range(0, 6), 1'($urandom), $urandom_range(0, 7),
                   1'($urandom), 1'b1);
      end
      check("no overflow before stall", 64'(overflow), 64'd0);

      // Stall the consumer: DEPTH storage + head + one pending survive, the rest drop.
      got.delete();
      exp_q.delete();
      ev_ready = 1'b0;
      base     = edge_n;
      for (int i = 0; i < 7; i++) begin
         dv[i & 7] = 8'($urandom);
         stb_flag = 1'b1;
         stb_data = dv[i & 7];
         tick();
         stb_flag = 1'b0;
         tick();
         if (i < 6) exp_q.push_back(mk(L_INFO, T_STBL, base + 2*i + 1, dv[i & 7], 1));
      end
      repeat (3) tick();
      check("ovf sticky", 64'(overflow), 64'd1);
      check("ovf head valid", 64'(ev_valid), 64'd1);
      check("ovf head first", 64'(cur), 64'(exp_q[0]));
      drain_and_compare("ovf drain");
      for (int i = 1; i < got.size(); i++) begin
         t_prev = got[i-1][55:24];
         t_cur  = got[i][55:24];
         check($sformatf("ovf ts increasing %0d", i), 64'(t_cur > t_prev), 64'd1);
      end
      check("overflow still set", 64'(overflow), 64'd1);
      check("payload held while stalled", 64'(hold_bad), 64'd0);

      // Reset in the middle of an observe window.
      got.delete();
      obs_active = 1'b1;
      obs_flag   = 1'b0;
      obs_limit  = 16'd8;
      obs_start  = 1'b1;
      tick();
      obs_start = 1'b0;
      check("busy before rst", 64'(obs_busy), 64'd1);
      repeat (2) tick();
      rst = 1'b1;
      #1;
      check("rst mid-wait outputs", outs, 64'd0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      edge_n = 0;
      obs_flag = 1'b1;
      repeat (12) tick();
      check("rst no record", 64'(got.size()), 64'd0);
      check("post rst outputs", outs, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
